// File: rtl/boot_uart_receiver_if.sv
// Character-side bundle of the boot UART receiver: serial line in, received
// characters and line status out.
interface boot_uart_receiver_if #(
    parameter int char_width = 8
);
    logic                  rx;
    logic                  out_valid;
    logic [char_width-1:0] out_char;
    logic                  framing_error;
    logic                  busy;

    modport master (
        input  rx,
        output out_valid,
        output out_char,
        output framing_error,
        output busy
    );

    modport slave (
        output rx,
        input  out_valid,
        input  out_char,
        input  framing_error,
        input  busy
    );
endinterface

// File: rtl/boot_uart_receiver.sv
// 8N1 UART receiver for the boot loader path: recovers one character per frame
// from the rx pin and presents it as a single-cycle valid pulse.
module boot_uart_receiver #(
    parameter int clk_frequency = 12_500_000,
    parameter int baud_rate     = 115200,
    parameter int char_width    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    boot_uart_receiver_if.master bus
);
    localparam int cycles_per_bit = clk_frequency / baud_rate;
    localparam int half_bit       = cycles_per_bit / 2;
    localparam int CNT_W          = $clog2(cycles_per_bit);
    localparam int IDX_W          = (char_width > 1) ? $clog2(char_width) : 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(half_bit - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(cycles_per_bit - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(char_width - 1);

    if (cycles_per_bit < 4) begin : g_rate_check
        $error("boot_uart_receiver: clk_frequency / baud_rate must be at least 4");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  rx_meta;
    logic                  rx_sync;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    logic                  shift_en;
    logic                  valid_set;
    logic                  ferr_set;
    logic [char_width-1:0] shift_reg;

    // Two-flop synchronizer; the line idles high, so reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!rx_sync) state_next = ST_START;
            ST_START: if (cnt == '0) state_next = rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:  if (cnt == '0 && idx == LAST_IDX) state_next = ST_STOP;
            ST_STOP:  if (cnt == '0) state_next = rx_sync ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_sync) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Bit timer and datapath controls; every decision is taken when cnt hits 0.
    always_comb begin
        cnt_next  = cnt;
        idx_next  = idx;
        shift_en  = 1'b0;
        valid_set = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_sync) cnt_next = HALF_LOAD;
            end
            ST_START: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (!rx_sync) begin
                    cnt_next = FULL_LOAD;
                    idx_next = '0;
                end
            end
            ST_DATA: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    shift_en = 1'b1;
                    cnt_next = FULL_LOAD;
                    if (idx != LAST_IDX) idx_next = idx + IDX_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (rx_sync) begin
                    valid_set = 1'b1;
                end else begin
                    ferr_set = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt               <= '0;
            idx               <= '0;
            bus.out_valid     <= 1'b0;
            bus.framing_error <= 1'b0;
            bus.busy          <= 1'b0;
            bus.out_char      <= '0;
        end else begin
            cnt               <= cnt_next;
            idx               <= idx_next;
            bus.out_valid     <= valid_set;
            bus.framing_error <= ferr_set;
            bus.busy          <= (state_next != ST_IDLE);
            if (valid_set) bus.out_char <= shift_reg;
        end
    end

    // LSB arrives first, so shifting right leaves it at bit 0 after the last bit.
    always_ff @(posedge clk) begin
        if (shift_en) shift_reg <= {rx_sync, shift_reg[char_width-1:1]};
    end
endmodule

// File: tb/tb_boot_uart_receiver.sv
// Bench for boot_uart_receiver: directed and random frames at the default rate
// plus a 10-cycle-per-bit instance driven with off-nominal bit periods.
module tb_boot_uart_receiver;
    localparam int CPB_A  = 12_500_000 / 115200;
    localparam int HALF_A = CPB_A / 2;
    localparam int LAT_A  = 3 + HALF_A + 9 * CPB_A;
    localparam int CLK_T  = 10;
    localparam int BIT_A  = CPB_A * CLK_T;

    typedef struct {
        bit         is_err;
        logic [7:0] ch;
        int         cyc;
        bit         chk_cyc;
    } item_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;
    bit         mon_on = 1'b0;
    logic       rst_q = 1'b1;
    item_t      qa[$];
    item_t      qb[$];
    item_t      it_a;
    item_t      it_b;
    logic [7:0] hold_a = 8'h00;
    logic [7:0] hold_b = 8'h00;

    boot_uart_receiver_if #(.char_width(8)) ifa ();
    boot_uart_receiver_if #(.char_width(8)) ifb ();

    boot_uart_receiver #(
        .clk_frequency(12_500_000),
        .baud_rate(115200),
        .char_width(8)
    ) dut_a (
        .clk(clk),
        .reset(reset),
        .bus(ifa)
    );

    boot_uart_receiver #(
        .clk_frequency(1_000_000),
        .baud_rate(100_000),
        .char_width(8)
    ) dut_b (
        .clk(clk),
        .reset(reset),
        .bus(ifb)
    );

    always #(CLK_T / 2) clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_item(input string tag, input item_t it, input logic v,
                                input logic fe, input logic [7:0] ch);
        check({tag, "_valid"}, int'(v), int'(!it.is_err));
        check({tag, "_framing_error"}, int'(fe), int'(it.is_err));
        if (!it.is_err) check({tag, "_char"}, int'(ch), int'(it.ch));
        if (it.chk_cyc) check({tag, "_latency_cycle"}, cyc, it.cyc);
    endtask

    // Scoreboard monitors: pop one expectation per output pulse.
    always @(negedge clk) begin
        if (mon_on) begin
            if (ifa.out_valid || ifa.framing_error) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_output", 1, 0);
                end else begin
                    it_a = qa.pop_front();
                    compare_item("a", it_a, ifa.out_valid, ifa.framing_error, ifa.out_char);
                end
            end
            if (rst_q) begin
                check("a_out_char_after_reset", int'(ifa.out_char), 0);
                check("a_busy_after_reset", int'(ifa.busy), 0);
            end else if (!ifa.out_valid) begin
                check("a_out_char_hold", int'(ifa.out_char), int'(hold_a));
            end
            hold_a = ifa.out_char;

            if (ifb.out_valid || ifb.framing_error) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_output", 1, 0);
                end else begin
                    it_b = qb.pop_front();
                    compare_item("b", it_b, ifb.out_valid, ifb.framing_error, ifb.out_char);
                end
            end
            if (rst_q) begin
                check("b_out_char_after_reset", int'(ifb.out_char), 0);
            end else if (!ifb.out_valid) begin
                check("b_out_char_hold", int'(ifb.out_char), int'(hold_b));
            end
            hold_b = ifb.out_char;
        end
    end

    task automatic set_rx(input bit sel_b, input logic v);
        if (sel_b) ifb.rx = v;
        else       ifa.rx = v;
    endtask

    // One 8N1 frame; the expectation is queued at the moment the start edge is driven.
    task automatic send_frame(input bit sel_b, input logic [7:0] ch, input logic stop,
                              input int bit_t, input bit chk);
        item_t it;
        it.is_err  = !stop;
        it.ch      = ch;
        it.cyc     = cyc + LAT_A;
        it.chk_cyc = chk;
        if (sel_b) qb.push_back(it);
        else       qa.push_back(it);
        set_rx(sel_b, 1'b0);
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel_b, ch[i]);
            #(bit_t);
        end
        set_rx(sel_b, stop);
        #(bit_t);
    endtask

    logic [7:0] b2b [4]   = '{8'h30, 8'h44, 8'h0D, 8'h0A};
    logic [7:0] tol_b [3] = '{8'h00, 8'hFF, 8'h81};
    int         tol_p [3] = '{97, 103, 100};

    initial begin
        logic [7:0] a5;
        logic [7:0] rb;
        int         per;
        ifa.rx = 1'b1;
        ifb.rx = 1'b1;
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a_out_valid", int'(ifa.out_valid), 0);
        check("reset_a_framing_error", int'(ifa.framing_error), 0);
        check("reset_a_busy", int'(ifa.busy), 0);
        check("reset_a_out_char", int'(ifa.out_char), 0);
        check("reset_b_out_valid", int'(ifb.out_valid), 0);
        check("reset_b_framing_error", int'(ifb.framing_error), 0);
        check("reset_b_busy", int'(ifb.busy), 0);
        check("reset_b_out_char", int'(ifb.out_char), 0);

        @(posedge clk);
        #3;
        reset  = 1'b0;
        mon_on = 1'b1;
        #(BIT_A);

        send_frame(0, 8'h41, 1'b1, BIT_A, 1);
        #(2 * BIT_A);

        // Short low pulse must be dropped at the start-bit check.
        ifa.rx = 1'b0;
        #(20 * CLK_T);
        ifa.rx = 1'b1;
        #((HALF_A + 5 - 20) * CLK_T);
        check("glitch_busy_dropped", int'(ifa.busy), 0);
        #(2 * BIT_A);
        send_frame(0, 8'h30, 1'b1, BIT_A, 1);
        #(2 * BIT_A);

        send_frame(0, 8'h55, 1'b0, BIT_A, 1);
        #(400 * CLK_T);
        check("break_busy_held", int'(ifa.busy), 1);
        #(100 * CLK_T);
        ifa.rx = 1'b1;
        #(5 * CLK_T);
        check("break_busy_released", int'(ifa.busy), 0);
        #(2 * BIT_A);
        send_frame(0, 8'h46, 1'b1, BIT_A, 1);
        #(2 * BIT_A);

        for (int i = 0; i < 4; i++) send_frame(0, b2b[i], 1'b1, BIT_A, 1);
        #(2 * BIT_A);

        // Abort 0xA5 in the middle of data bit 3 with a one-cycle reset.
        a5 = 8'hA5;
        ifa.rx = 1'b0;
        #(BIT_A);
        for (int i = 0; i < 3; i++) begin
            ifa.rx = a5[i];
            #(BIT_A);
        end
        ifa.rx = a5[3];
        #(BIT_A / 2);
        reset = 1'b1;
        #(CLK_T);
        reset  = 1'b0;
        ifa.rx = 1'b1;
        #(2 * CLK_T);
        check("abort_busy", int'(ifa.busy), 0);
        check("abort_out_valid", int'(ifa.out_valid), 0);
        #(12 * BIT_A);
        send_frame(0, 8'h5A, 1'b1, BIT_A, 1);
        #(2 * BIT_A);

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            send_frame(0, rb, 1'b1, BIT_A, 1);
            #(CLK_T * $urandom_range(0, 200));
        end
        #(2 * BIT_A);

        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                send_frame(1, tol_b[i], 1'b1, tol_p[p], 0);
                #(3 * tol_p[p]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            per = tol_p[$urandom_range(0, 2)];
            rb  = 8'($urandom);
            send_frame(1, rb, 1'b1, per, 0);
            #(per * $urandom_range(0, 4));
        end

        for (int i = 0; i < 3000 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
        #1;
        check("queues_drained", qa.size() + qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(80_000 * CLK_T);
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule

// File: doc/boot_uart_receiver.md
# boot_uart_receiver

Serial-to-character front end of the boot loader path: recovers 8N1 asynchronous UART frames from the `rx` pin and emits one character per frame as a single-cycle valid pulse. Its `out_valid`/`out_char` pair drives the `in_valid`/`in_char` inputs of the boot hex parser directly. It sits between the board UART pin and the hex parser, in the same clock domain as the parser.

## Interface
- `clk_frequency`, default 12_500_000: system clock frequency in Hz.
- `baud_rate`, default 115200: line rate in bits per second.
- `char_width`, default 8: data bits per frame.
- Derived: `cycles_per_bit = clk_frequency / baud_rate` (integer division; 108 at defaults).
- Derived: `half_bit = cycles_per_bit / 2` (54 at defaults).
- Elaboration fails if `cycles_per_bit < 4`.

Ports:
- `clk`  input  1  system clock. One clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous serial line; idles high.
- `out_valid`  output  1  one-cycle pulse: `out_char` holds a newly received character.
- `out_char`  output  `char_width`  received character, LSB received first.
- `framing_error`  output  1  one-cycle pulse: stop bit sampled low.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- **Input synchronizer:** `rx` passes through two flops, `rx_meta` and then `rx_sync`. Both reset to 1. All decisions use `rx_sync` only.
- **Bit timer:** a down-counter of width `$clog2(cycles_per_bit)` and a bit index of width `$clog2(char_width)`. There is no separate sampling pulse; the state machine acts in the cycle where the counter is 0.
- **State machine:**
  - IDLE: if `rx_sync == 0`, load counter with `half_bit - 1` and go to START.
  - START: decrement counter while nonzero. At 0:
    - if `rx_sync == 0`, load `cycles_per_bit - 1`, clear the bit index and go to DATA;
    - otherwise (glitch) go to IDLE with no output.
  - DATA: decrement counter while nonzero. At 0, shift `rx_sync` into the MSB of the shift register (right shift, so the first bit ends up in the LSB) and reload `cycles_per_bit - 1`. If the bit index equals `char_width - 1`, go to STOP; otherwise increment the bit index.
  - STOP: decrement counter while nonzero. At 0:
    - if `rx_sync == 1`, set `out_valid` for one cycle, load `out_char` from the shift register and go to IDLE;
    - otherwise pulse `framing_error` for one cycle and go to BREAK.
  - BREAK: wait for `rx_sync == 1`, then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- **Output hold:** `out_char` changes only when `out_valid` is asserted and holds its value otherwise. The shift register is not reset.
- **Back-to-back frames:** a start bit may follow the stop-bit sample immediately. IDLE is entered on the stop-sample edge and checks `rx_sync` on the next edge.
- **No backpressure:** the downstream parser accepts every character.

## Timing
- **Reset values:** `out_valid` = 0, `framing_error` = 0, `busy` = 0, `out_char` = 0, state = IDLE, counter = 0, bit index = 0, `rx_meta` = `rx_sync` = 1.
- **Latency:** number the first rising edge that samples `rx` low as edge 1.
  - IDLE→START transition happens at edge 3.
  - Start bit is checked at edge `3 + half_bit` (57 at defaults).
  - Data bit k is sampled at edge `3 + half_bit + (k+1)·cycles_per_bit`.
  - Stop bit is sampled at edge `3 + half_bit + (char_width+1)·cycles_per_bit` (1029 at defaults).
  - `out_valid` is high for exactly the one cycle after that edge. `framing_error` follows the same timing.
- **Outputs:** `out_valid` and `framing_error` are registered and never both high. `busy` is registered and follows the state register.
- **Reset mid-frame:** returns to IDLE on the next edge. No `out_valid` or `framing_error` is produced for the aborted frame.
- **Simultaneous `reset` and stop-bit sample:** reset wins and there is no output pulse.

## Test plan
- **Single character:** at defaults, send 0x41 with a 108-cycle bit period, then idle → `out_valid` is a single pulse one cycle after edge 1029, with `out_char` = 0x41 and `framing_error` = 0.
- **Glitch rejection:** drive `rx` low for 20 cycles, then high → no `out_valid` and no `framing_error`; `busy` drops by edge 57; a following 0x30 frame is received correctly.
- **Framing error:** send 0x55 with the stop bit low, hold low for 500 cycles, then release → one `framing_error` pulse and no `out_valid`; `busy` stays high until `rx_sync` returns to 1; a next frame 0x46 is received.
- **Back-to-back frames:** send "0D\r\n" (0x30, 0x44, 0x0D, 0x0A) with zero idle between stop and start bits → four `out_valid` pulses, 1080 cycles apart, with the correct values.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0xA5 → no output for that frame; a following 0x5A frame gives `out_char` = 0x5A.
- **Baud tolerance:** set `clk_frequency` = 1_000_000 and `baud_rate` = 100000 (`cycles_per_bit` = 10), and drive bits at ±3 % period → all bytes 0x00, 0xFF and 0x81 are received correctly.
